// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank and the display mux.
package perf_pkg;

   // Run/freeze FSM encoding; the display mux decodes these values directly.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2
   } perf_state_t;

   localparam int DEF_NUM_CH = 4;
   localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/perf_counter_cell.sv
// One live event counter with its sticky overflow flag.
// Wraps to zero or holds at all-ones on overflow, selected by SATURATE.
module perf_counter_cell #(
   parameter int CNT_W    = 32,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             ovf_reg, ovf_next;

   // Next-state: clear dominates; an increment from all-ones flags overflow.
   always_comb begin
      cnt_next = cnt_reg;
      ovf_next = ovf_reg;
      if (clr) begin
         cnt_next = '0;
         ovf_next = 1'b0;
      end else if (inc) begin
         if (cnt_reg == '1) begin
            ovf_next = 1'b1;
            cnt_next = (SATURATE != 0) ? cnt_reg : '0;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   // Counter and overflow state, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         ovf_reg <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         ovf_reg <= ovf_next;
      end
   end

   assign cnt = cnt_reg;
   assign ovf = ovf_reg;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters beside the CPU core: run/freeze FSM,
// per-channel live counters, snapshot shadows and a registered readout.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int SATURATE = 0,
   parameter int CYCLE_CH = 1,
   parameter int SEL_W    = $clog2(NUM_CH)
) (
   input  logic              clkN,
   input  logic              rst,
   input  logic              start,
   input  logic              halt,
   input  logic              clr,
   input  logic              snap,
   input  logic [NUM_CH-1:0] ev,
   input  logic [SEL_W-1:0]  sel,
   output logic [CNT_W-1:0]  rd_data,
   output logic [NUM_CH-1:0] ovf,
   output logic              run
);

   localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

   perf_state_t      state_reg;
   logic             run_reg;
   logic [CNT_W-1:0] live       [NUM_CH];
   logic [CNT_W-1:0] shadow_reg [NUM_CH];
   logic [CNT_W-1:0] rd_data_reg;
   logic [NUM_CH-1:0] ovf_vec;

   // FSM with registered run flag; clr returns to IDLE from any state and beats start.
   always_ff @(posedge clkN or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         run_reg   <= 1'b0;
      end else if (clr) begin
         state_reg <= ST_IDLE;
         run_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: if (start) begin
               state_reg <= ST_RUN;
               run_reg   <= 1'b1;
            end
            ST_RUN: if (halt) begin
               state_reg <= ST_FROZEN;
               run_reg   <= 1'b0;
            end
            ST_FROZEN: begin
               state_reg <= ST_FROZEN;
               run_reg   <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
               run_reg   <= 1'b0;
            end
         endcase
      end
   end

   // Counting is gated on the registered state, so the start cycle is skipped
   // and the halt cycle (still in RUN) is included.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic inc;
         assign inc = (state_reg == ST_RUN) &&
                      (ev[gi] || (gi == 0 && CYCLE_CH != 0));
         perf_counter_cell #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
         ) u_cell (
            .clk   (clkN),
            .rst_n (rst),
            .inc   (inc),
            .clr   (clr),
            .cnt   (live[gi]),
            .ovf   (ovf_vec[gi])
         );
      end
   endgenerate

   // Snapshot captures the pre-increment / pre-clear live values.
   always_ff @(posedge clkN or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) shadow_reg[i] <= '0;
      end else if (snap) begin
         for (int i = 0; i < NUM_CH; i++) shadow_reg[i] <= live[i];
      end
   end

   // Registered readout of the selected shadow; out-of-range selects read zero.
   always_ff @(posedge clkN or negedge rst) begin
      if (!rst) begin
         rd_data_reg <= '0;
      end else if ({1'b0, sel} < NUM_CH_L) begin
         rd_data_reg <= shadow_reg[sel];
      end else begin
         rd_data_reg <= '0;
      end
   end

   assign rd_data = rd_data_reg;
   assign ovf     = ovf_vec;
   assign run     = run_reg;

endmodule
